pong_game_ctrl: RTL and testbench

- Game-flow controller that sequences the Pong ball datapath.
- Holds the ball at centre, serves it after a delay with a pseudo-random non-zero angle, and gates per-frame motion.
- Detects misses at the field edges, keeps both scores, and handles pause and game-over.
- Sits between the top-level input debouncers and ball_movement: drives the ball's load/enable/serve inputs and consumes its x position.

---
 rtl/pong_game_ctrl_if.sv | 35 +++
 rtl/pong_game_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_game_ctrl_if.sv
// rtl/pong_game_ctrl_if.sv - ball datapath bus between the game controller and ball_movement
//
// Signals:
//   ball_x      ball_movement -> controller : current ball x coordinate
//   ball_load   controller -> ball_movement : hold/reload the ball at centre
//   ball_en     controller -> ball_movement : one-clk move strobe
//   serve_dir   controller -> ball_movement : 0 = serve left, 1 = serve right
//   serve_angle controller -> ball_movement : signed serve angle in degrees, never 0
// Modports: master = controller side, slave = ball_movement side.

interface pong_game_ctrl_if #(
    parameter int FIELD_W = 6
);
    logic [FIELD_W-1:0] ball_x;
    logic               ball_load;
    logic               ball_en;
    logic               serve_dir;
    logic [7:0]         serve_angle;

    modport master (
        input  ball_x,
        output ball_load,
        output ball_en,
        output serve_dir,
        output serve_angle
    );

    modport slave (
        output ball_x,
        input  ball_load,
        input  ball_en,
        input  serve_dir,
        input  serve_angle
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - Pong game-flow controller: serve sequencing, scoring, pause and game-over
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   frame_tick  one-clk pulse per video frame
//   start       debounced start button (level)
//   pause_btn   debounced pause button (level)
//   ball        ball datapath bus (master side): ball_x in; ball_load, ball_en,
//               serve_dir, serve_angle out
//   score_l     left player score
//   score_r     right player score
//   point_flag  one-clk pulse when a point is awarded
//   game_over   high while in OVER
//   state       current FSM state (debug)

module pong_game_ctrl #(
    parameter int         FIELD_W     = 6,
    parameter int         SCORE_W     = 4,
    parameter int         WIN_SCORE   = 11,
    parameter int         SERVE_DELAY = 60,
    parameter int         MAX_ANGLE   = 45,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic                 start,
    input  logic                 pause_btn,
    pong_game_ctrl_if.master     ball,
    output logic [SCORE_W-1:0]   score_l,
    output logic [SCORE_W-1:0]   score_r,
    output logic                 point_flag,
    output logic                 game_over,
    output logic [2:0]           state
);

    localparam int CNT_W = $clog2(SERVE_DELAY + 1);

    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(SERVE_DELAY);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);
    localparam logic [FIELD_W-1:0] X_MAX     = '1;
    localparam logic [5:0]         ANG_MAX   = 6'(MAX_ANGLE);
    // Galois taps for x^8+x^6+x^5+x^4+1 in a right-shifting register
    localparam logic [7:0]         LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SERVE_WAIT = 3'd1,
        S_SERVE      = 3'd2,
        S_PLAY       = 3'd3,
        S_POINT      = 3'd4,
        S_PAUSED     = 3'd5,
        S_OVER       = 3'd6
    } state_t;

    state_t             cur_state;
    state_t             nxt_state;
    logic               start_d;
    logic               pause_d;
    logic               start_rise;
    logic               pause_rise;
    logic [7:0]         lfsr;
    logic [7:0]         lfsr_next;
    logic [CNT_W-1:0]   cnt;
    logic               right_scores;
    logic               left_scores;
    logic [SCORE_W-1:0] score_l_inc;
    logic [SCORE_W-1:0] score_r_inc;
    logic               win;
    logic [5:0]         ang_raw;
    logic [5:0]         ang_mod;
    logic [7:0]         ang_mag;
    logic [7:0]         ang_sample;
    logic               load_c;
    logic               en_c;
    logic               dir_q;
    logic [7:0]         angle_q;

    assign start_rise = start & ~start_d;
    assign pause_rise = pause_btn & ~pause_d;

    assign lfsr_next = lfsr[0] ? ({1'b0, lfsr[7:1]} ^ LFSR_TAPS) : {1'b0, lfsr[7:1]};

    // Fold 0..63 onto 0..MAX_ANGLE-1 with a single subtract, then shift off zero
    assign ang_raw    = lfsr[5:0];
    assign ang_mod    = (ang_raw >= ANG_MAX) ? (ang_raw - ANG_MAX) : ang_raw;
    assign ang_mag    = {2'b00, ang_mod} + 8'd1;
    assign ang_sample = lfsr[7] ? (8'd0 - ang_mag) : ang_mag;

    assign right_scores = (ball.ball_x == '0);
    assign left_scores  = (ball.ball_x == X_MAX);

    // In POINT, serve_dir already names the scorer: 0 means the right player scored
    assign score_l_inc = score_l + 1'b1;
    assign score_r_inc = score_r + 1'b1;
    assign win         = dir_q ? (score_l_inc == SCORE_WIN) : (score_r_inc == SCORE_WIN);

    assign ball.ball_load   = load_c;
    assign ball.ball_en     = en_c;
    assign ball.serve_dir   = dir_q;
    assign ball.serve_angle = angle_q;
    assign state            = cur_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state  = cur_state;
        load_c     = 1'b1;
        en_c       = 1'b0;
        point_flag = 1'b0;
        game_over  = 1'b0;
        case (cur_state)
            S_IDLE: begin
                if (start_rise) nxt_state = S_SERVE_WAIT;
            end
            S_SERVE_WAIT: begin
                if (frame_tick && (cnt == CNT_LAST)) nxt_state = S_SERVE;
            end
            S_SERVE: begin
                nxt_state = S_PLAY;
            end
            S_PLAY: begin
                load_c = 1'b0;
                en_c   = frame_tick;
                // A miss outranks a pause request in the same cycle
                if (right_scores || left_scores) nxt_state = S_POINT;
                else if (pause_rise)             nxt_state = S_PAUSED;
            end
            S_POINT: begin
                load_c     = 1'b0;
                point_flag = 1'b1;
                nxt_state  = win ? S_OVER : S_SERVE_WAIT;
            end
            S_PAUSED: begin
                load_c = 1'b0;
                if (pause_rise) nxt_state = S_PLAY;
            end
            S_OVER: begin
                game_over = 1'b1;
                if (start_rise) nxt_state = S_SERVE_WAIT;
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_d <= 1'b0;
            pause_d <= 1'b0;
            lfsr    <= LFSR_SEED;
            cnt     <= '0;
            score_l <= '0;
            score_r <= '0;
            dir_q   <= 1'b1;
            angle_q <= 8'd1;
        end else begin
            start_d <= start;
            pause_d <= pause_btn;
            lfsr    <= lfsr_next;
            case (cur_state)
                S_IDLE, S_OVER: begin
                    if (start_rise) begin
                        score_l <= '0;
                        score_r <= '0;
                        cnt     <= CNT_LOAD;
                    end
                end
                S_SERVE_WAIT: begin
                    if (frame_tick) cnt <= cnt - 1'b1;
                end
                S_SERVE: begin
                    angle_q <= ang_sample;
                end
                S_PLAY: begin
                    if (right_scores)     dir_q <= 1'b0;
                    else if (left_scores) dir_q <= 1'b1;
                end
                S_POINT: begin
                    if (dir_q) score_l <= score_l_inc;
                    else       score_r <= score_r_inc;
                    if (!win)  cnt <= CNT_LOAD;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - self-checking bench for pong_game_ctrl

module tb_pong_game_ctrl;

    localparam int SERVE_DELAY = 4;
    localparam int WIN_SCORE   = 3;
    localparam int MAX_ANGLE   = 45;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       pause_btn = 1'b0;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       point_flag;
    logic       game_over;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;

    pong_game_ctrl_if #(.FIELD_W(6)) bif ();

    pong_game_ctrl #(
        .FIELD_W    (6),
        .SCORE_W    (4),
        .WIN_SCORE  (WIN_SCORE),
        .SERVE_DELAY(SERVE_DELAY),
        .MAX_ANGLE  (MAX_ANGLE),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .frame_tick(frame_tick),
        .start     (start),
        .pause_btn (pause_btn),
        .ball      (bif),
        .score_l   (score_l),
        .score_r   (score_r),
        .point_flag(point_flag),
        .game_over (game_over),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] l;
        logic [3:0] r;
        logic       dir;
        logic [2:0] ns;
    } pt_t;

    pt_t        point_q[$];
    logic [7:0] angle_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, one step per clock
    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        logic [7:0] s;
        s = {1'b0, l[7:1]};
        if (l[0]) s = s ^ 8'b1011_1000;
        return s;
    endfunction

    function automatic logic [7:0] exp_angle(input logic [7:0] l);
        int m;
        int mag;
        m = int'(l[5:0]);
        if (m >= MAX_ANGLE) m = m - MAX_ANGLE;
        mag = m + 1;
        return l[7] ? 8'(-mag) : 8'(mag);
    endfunction

    logic [7:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    // Serve monitor: expected angle taken from the model at the SERVE cycle,
    // compared once the DUT enters PLAY
    logic [2:0] prev_state = 3'd0;
    logic       saw_pos = 1'b0;
    logic       saw_neg = 1'b0;
    initial begin
        logic signed [7:0] a;
        forever begin
            @(negedge clk);
            if (rst_n && state == 3'd2) angle_q.push_back(exp_angle(m_lfsr));
            if (rst_n && state == 3'd3 && prev_state == 3'd2) begin
                a = bif.serve_angle;
                if (angle_q.size() == 0) begin
                    check("angle_queue_empty", 0, 1);
                end else begin
                    check("serve_angle", bif.serve_angle, angle_q.pop_front());
                end
                check("angle_range", (a != 0 && a >= -45 && a <= 45), 1);
                if (a > 0) saw_pos = 1'b1;
                if (a < 0) saw_neg = 1'b1;
            end
            prev_state = state;
        end
    end

    // Point monitor: on point_flag, pop the expected outcome and check it a clock later
    initial begin
        pt_t e;
        forever begin
            @(negedge clk);
            if (point_flag) begin
                if (point_q.size() == 0) begin
                    check("unexpected_point", 1, 0);
                end else begin
                    e = point_q.pop_front();
                    check("point_state", state, 3'd4);
                    check("point_dir", bif.serve_dir, e.dir);
                    @(negedge clk);
                    check("point_pulse_1clk", point_flag, 0);
                    check("score_l", score_l, e.l);
                    check("score_r", score_r, e.r);
                    check("after_point_state", state, e.ns);
                    check("game_over", game_over, (e.ns == 3'd6));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic press_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic serve_to_play();
        int n;
        n = 0;
        frame_tick = 1'b1;
        while (state != 3'd3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        frame_tick = 1'b0;
        check("serve_reached_play", state, 3'd3);
    endtask

    task automatic miss(input logic [5:0] x, input logic pz, input pt_t e);
        point_q.push_back(e);
        bif.ball_x = x;
        pause_btn  = pz;
        @(negedge clk);
        bif.ball_x = 6'd31;
        @(negedge clk);
        pause_btn = 1'b0;
    endtask

    initial begin
        int ticks;
        logic load_bad;
        int l;
        int r;
        logic [5:0] x;
        pt_t e;

        bif.ball_x = 6'd31;
        repeat (3) @(negedge clk);
        check("rst_state", state, 3'd0);
        check("rst_ball_load", bif.ball_load, 1);
        check("rst_ball_en", bif.ball_en, 0);
        check("rst_point_flag", point_flag, 0);
        check("rst_game_over", game_over, 0);
        check("rst_scores", {score_l, score_r}, 8'h00);
        check("rst_serve_dir", bif.serve_dir, 1);
        check("rst_serve_angle", bif.serve_angle, 8'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Serve timing: frame_tick every 10 clk, exactly SERVE_DELAY ticks at centre
        press_start();
        check("start_to_serve_wait", state, 3'd1);
        ticks = 0;
        load_bad = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (state != 3'd1) break;
            if (!bif.ball_load) load_bad = 1'b1;
            frame_tick = (c % 10 == 9);
            if (frame_tick) ticks++;
            @(negedge clk);
        end
        frame_tick = 1'b0;
        check("serve_wait_ticks", ticks, SERVE_DELAY);
        check("serve_wait_load", load_bad, 0);
        check("serve_state", state, 3'd2);
        check("serve_load", bif.ball_load, 1);
        @(negedge clk);
        check("play_after_1clk_serve", state, 3'd3);
        frame_tick = 1'b1;
        #1;
        check("play_ball_en_hi", bif.ball_en, 1);
        check("play_ball_load", bif.ball_load, 0);
        frame_tick = 1'b0;
        #1;
        check("play_ball_en_lo", bif.ball_en, 0);

        // Misses at each edge
        e = '{l: 4'd0, r: 4'd1, dir: 1'b0, ns: 3'd1};
        miss(6'd0, 1'b0, e);
        serve_to_play();
        e = '{l: 4'd1, r: 4'd1, dir: 1'b1, ns: 3'd1};
        miss(6'd63, 1'b0, e);

        // Pause freezes motion; held button gives a single transition
        serve_to_play();
        pause_btn = 1'b1;
        @(negedge clk);
        check("paused_state", state, 3'd5);
        for (int c = 0; c < 20; c++) begin
            frame_tick = (c % 4 == 0);
            #1;
            check("paused_ball_en", bif.ball_en, 0);
            @(negedge clk);
        end
        frame_tick = 1'b0;
        check("paused_held", state, 3'd5);
        pause_btn = 1'b0;
        repeat (2) @(negedge clk);
        pause_btn = 1'b1;
        @(negedge clk);
        check("resume_play", state, 3'd3);
        repeat (20) @(negedge clk);
        check("resume_held", state, 3'd3);
        pause_btn = 1'b0;
        repeat (2) @(negedge clk);

        // Miss and pause edge in the same cycle: the point wins
        e = '{l: 4'd2, r: 4'd1, dir: 1'b1, ns: 3'd1};
        miss(6'd63, 1'b1, e);

        // Right reaches WIN_SCORE
        serve_to_play();
        e = '{l: 4'd2, r: 4'd2, dir: 1'b0, ns: 3'd1};
        miss(6'd0, 1'b0, e);
        serve_to_play();
        e = '{l: 4'd2, r: 4'd3, dir: 1'b0, ns: 3'd6};
        miss(6'd0, 1'b0, e);
        check("over_state", state, 3'd6);
        check("over_load", bif.ball_load, 1);
        pause_btn = 1'b1;
        @(negedge clk);
        check("over_ignores_pause", state, 3'd6);
        pause_btn = 1'b0;
        @(negedge clk);
        press_start();
        check("restart_state", state, 3'd1);
        check("restart_scores", {score_l, score_r}, 8'h00);

        // Async reset mid-rally
        serve_to_play();
        e = '{l: 4'd1, r: 4'd0, dir: 1'b1, ns: 3'd1};
        miss(6'd63, 1'b0, e);
        serve_to_play();
        #2;
        rst_n = 1'b0;
        bif.ball_x = 6'd0;
        #1;
        check("arst_state", state, 3'd0);
        check("arst_load", bif.ball_load, 1);
        check("arst_en", bif.ball_en, 0);
        check("arst_point", point_flag, 0);
        check("arst_scores", {score_l, score_r}, 8'h00);
        check("arst_dir", bif.serve_dir, 1);
        check("arst_angle", bif.serve_angle, 8'd1);
        @(negedge clk);
        check("arst_no_point", point_flag, 0);
        bif.ball_x = 6'd31;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_idle_hold", state, 3'd0);

        // 1000 serves through several games
        press_start();
        l = 0;
        r = 0;
        for (int i = 0; i < 1000; i++) begin
            serve_to_play();
            if (i % 2 == 0) begin
                x = 6'd63;
                l++;
            end else begin
                x = 6'd0;
                r++;
            end
            e.l   = 4'(l);
            e.r   = 4'(r);
            e.dir = (x == 6'd63);
            e.ns  = (l == WIN_SCORE || r == WIN_SCORE) ? 3'd6 : 3'd1;
            miss(x, 1'b0, e);
            if (e.ns == 3'd6) begin
                l = 0;
                r = 0;
                press_start();
            end
        end
        check("angle_pos_seen", saw_pos, 1);
        check("angle_neg_seen", saw_neg, 1);

        repeat (4) @(negedge clk);
        check("point_queue_drained", point_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
